// File: rtl/final_fpga_cpu_oci_trace_packer.sv
// -----------------------------------------------------------------------------
// final_fpga_cpu_oci_trace_packer
//
// Packs fixed-width OCI trace slots into words of SLOTS slots and queues the
// completed words in a small FIFO. The words leave through a valid/ready
// stream. When test_ending is seen, the packer flushes its partial word,
// waits for the FIFO to drain, and then raises a sticky test_has_ended.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high reset
//   slot_valid     : a trace slot is present this cycle
//   slot_data      : trace slot payload (SLOT_W bits)
//   slot_ready     : slots are accepted (high only while running)
//   sync_flush     : emit the current partial word now
//   test_ending    : start the end-of-test flush and drain
//   out_valid      : the FIFO head is valid
//   out_ready      : the sink accepts the head
//   dct_buffer     : FIFO head word (slot k at bits SLOT_W*k +: SLOT_W)
//   dct_count      : number of valid slots in the head word (1..SLOTS)
//   test_has_ended : sticky, set once the flush and drain are complete
//   overflow       : sticky, set when at least one word was dropped
//   ovf_count      : number of dropped words, saturating
// -----------------------------------------------------------------------------
module final_fpga_cpu_oci_trace_packer #(
    parameter int SLOT_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 4,
    parameter int OVF_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    slot_valid,
    input  logic [SLOT_W-1:0]       slot_data,
    output logic                    slot_ready,
    input  logic                    sync_flush,
    input  logic                    test_ending,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SLOT_W*SLOTS-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    test_has_ended,
    output logic                    overflow,
    output logic [OVF_W-1:0]        ovf_count
);

    localparam int WORD_W = SLOT_W * SLOTS;
    localparam int ENT_W  = WORD_W + CNT_W;
    // The head register holds one word, so the backing store keeps DEPTH-1.
    localparam int STORE_N = DEPTH - 1;
    localparam int SPTR_W  = (STORE_N > 1) ? $clog2(STORE_N) : 1;
    localparam int SCNT_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   pbuf_reg, pbuf_next;
    logic [CNT_W-1:0]    pcount_reg, pcount_next;

    logic [ENT_W-1:0]    store_mem [STORE_N];
    logic [SPTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [SCNT_W-1:0]   store_cnt_reg;

    logic                head_valid_reg;
    logic [WORD_W-1:0]   head_word_reg;
    logic [CNT_W-1:0]    head_cnt_reg;

    logic                overflow_reg;
    logic [OVF_W-1:0]    ovf_count_reg;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                accept;
    logic [WORD_W-1:0]   ins_word;
    logic                push_req;
    logic [WORD_W-1:0]   push_word;
    logic [CNT_W-1:0]    push_cnt;
    logic                pop;
    logic                head_free;
    logic                store_empty;
    logic                store_full;
    logic                fifo_empty;
    logic                drop;
    logic                push;
    logic                store_wr;
    logic                store_rd;

    function automatic logic [SPTR_W-1:0] ptr_inc(input logic [SPTR_W-1:0] p);
        return (p == SPTR_W'(STORE_N - 1)) ? '0 : p + SPTR_W'(1);
    endfunction

    assign slot_ready = (state_reg == ST_RUN);
    assign accept     = slot_valid & slot_ready;

    // The partial buffer with the incoming slot dropped into position pcount.
    // A per-slot mux avoids a variable-width barrel shifter.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_insert
            assign ins_word[gi*SLOT_W +: SLOT_W] =
                (pcount_reg == CNT_W'(gi)) ? slot_data
                                           : pbuf_reg[gi*SLOT_W +: SLOT_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Packer and end-of-test sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        pbuf_next   = pbuf_reg;
        pcount_next = pcount_reg;
        push_req    = 1'b0;
        push_word   = pbuf_reg;
        push_cnt    = pcount_reg;

        unique case (state_reg)
            ST_RUN: begin
                if (accept) begin
                    // A flush in the same cycle includes the accepted slot.
                    if ((pcount_reg == CNT_W'(SLOTS - 1)) || sync_flush) begin
                        push_req    = 1'b1;
                        push_word   = ins_word;
                        push_cnt    = pcount_reg + CNT_W'(1);
                        pbuf_next   = '0;
                        pcount_next = '0;
                    end else begin
                        pbuf_next   = ins_word;
                        pcount_next = pcount_reg + CNT_W'(1);
                    end
                end else if (sync_flush && (pcount_reg != '0)) begin
                    push_req    = 1'b1;
                    pbuf_next   = '0;
                    pcount_next = '0;
                end
                if (test_ending) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pcount_reg != '0) begin
                    push_req = 1'b1;
                end
                pbuf_next   = '0;
                pcount_next = '0;
                state_next  = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_next = ST_ENDED;
                end
            end
            ST_ENDED: begin
                state_next = ST_ENDED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            pbuf_reg   <= '0;
            pcount_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pbuf_reg   <= pbuf_next;
            pcount_reg <= pcount_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO: registered head plus a circular backing store
    // ------------------------------------------------------------------
    assign pop         = head_valid_reg & out_ready;
    assign head_free   = ~head_valid_reg | pop;
    assign store_empty = (store_cnt_reg == '0);
    assign store_full  = (store_cnt_reg == SCNT_W'(STORE_N));
    assign fifo_empty  = ~head_valid_reg & store_empty;

    // Full means head valid and store full; a simultaneous pop makes room.
    assign drop     = push_req & head_valid_reg & store_full & ~pop;
    assign push     = push_req & ~drop;
    // A push bypasses the store only when it can go straight into the head.
    assign store_wr = push & ~(head_free & store_empty);
    assign store_rd = head_free & ~store_empty;

    always_ff @(posedge clk) begin
        if (store_wr) begin
            store_mem[wr_ptr_reg] <= {push_cnt, push_word};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_reg <= 1'b0;
            head_word_reg  <= '0;
            head_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            store_cnt_reg  <= '0;
            overflow_reg   <= 1'b0;
            ovf_count_reg  <= '0;
        end else begin
            if (head_free) begin
                if (!store_empty) begin
                    head_valid_reg <= 1'b1;
                    {head_cnt_reg, head_word_reg} <= store_mem[rd_ptr_reg];
                end else if (push) begin
                    head_valid_reg <= 1'b1;
                    head_word_reg  <= push_word;
                    head_cnt_reg   <= push_cnt;
                end else begin
                    // Word and count keep their last values while idle.
                    head_valid_reg <= 1'b0;
                end
            end

            if (store_wr) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (store_rd) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            unique case ({store_wr, store_rd})
                2'b10:   store_cnt_reg <= store_cnt_reg + SCNT_W'(1);
                2'b01:   store_cnt_reg <= store_cnt_reg - SCNT_W'(1);
                default: store_cnt_reg <= store_cnt_reg;
            endcase

            if (drop) begin
                overflow_reg <= 1'b1;
                if (ovf_count_reg != {OVF_W{1'b1}}) begin
                    ovf_count_reg <= ovf_count_reg + OVF_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid      = head_valid_reg;
    assign dct_buffer     = head_word_reg;
    assign dct_count      = head_cnt_reg;
    assign test_has_ended = (state_reg == ST_ENDED);
    assign overflow       = overflow_reg;
    assign ovf_count      = ovf_count_reg;

endmodule

// File: tb/tb_final_fpga_cpu_oci_trace_packer.sv
// -----------------------------------------------------------------------------
// Testbench for final_fpga_cpu_oci_trace_packer.
// Random stimulus in phases with different input densities; every cycle the
// DUT outputs are compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_final_fpga_cpu_oci_trace_packer;

    localparam int SLOT_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 4;
    localparam int OVF_W  = 8;
    localparam int W      = SLOT_W * SLOTS;
    localparam int OVF_MAX = (1 << OVF_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              slot_valid;
    logic [SLOT_W-1:0] slot_data;
    logic              slot_ready;
    logic              sync_flush;
    logic              test_ending;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      dct_buffer;
    logic [CNT_W-1:0]  dct_count;
    logic              test_has_ended;
    logic              overflow;
    logic [OVF_W-1:0]  ovf_count;

    final_fpga_cpu_oci_trace_packer #(
        .SLOT_W(SLOT_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
    ) dut (
        .clk(clk), .reset(reset), .slot_valid(slot_valid), .slot_data(slot_data),
        .slot_ready(slot_ready), .sync_flush(sync_flush), .test_ending(test_ending),
        .out_valid(out_valid), .out_ready(out_ready), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_has_ended(test_has_ended), .overflow(overflow),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_words = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending slots, queued words, phase of the test
    // (0 running, 1 flushing, 2 draining, 3 ended)
    // ------------------------------------------------------------------
    int           m_phase;
    int           m_slots[$];
    logic [W-1:0] m_qw[$];
    int           m_qc[$];
    bit           m_overflow;
    int           m_ovf;
    bit           m_after_rst;

    task automatic model_reset();
        m_phase = 0;
        m_slots.delete();
        m_qw.delete();
        m_qc.delete();
        m_overflow = 1'b0;
        m_ovf = 0;
        m_after_rst = 1'b1;
    endtask

    task automatic model_step(input bit rst, input bit sv, input int sd,
                              input bit sf, input bit te, input bit ordy);
        bit           have_word;
        logic [W-1:0] wd;
        int           wc;
        int           nphase;
        bit           do_pop;
        if (rst) begin
            model_reset();
            return;
        end
        m_after_rst = 1'b0;
        have_word = 1'b0;
        wd = '0;
        wc = 0;
        nphase = m_phase;
        do_pop = (m_qw.size() > 0) && ordy;
        case (m_phase)
            0: begin
                if (sv) m_slots.push_back(sd);
                if (m_slots.size() == SLOTS || (sf && m_slots.size() > 0)) have_word = 1'b1;
                if (te) nphase = 1;
            end
            1: begin
                if (m_slots.size() > 0) have_word = 1'b1;
                nphase = 2;
            end
            2: if (m_qw.size() == 0) nphase = 3;
            default: ;
        endcase
        if (have_word) begin
            for (int k = 0; k < m_slots.size(); k++) begin
                wd = wd | (W'(m_slots[k]) << (SLOT_W * k));
            end
            wc = m_slots.size();
            m_slots.delete();
        end
        if (do_pop) begin
            void'(m_qw.pop_front());
            void'(m_qc.pop_front());
        end
        if (have_word) begin
            if (m_qw.size() < DEPTH) begin
                m_qw.push_back(wd);
                m_qc.push_back(wc);
            end else begin
                m_overflow = 1'b1;
                if (m_ovf < OVF_MAX) m_ovf++;
            end
        end
        m_phase = nphase;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(m_qw.size() > 0));
        check_eq("slot_ready", 64'(slot_ready), 64'(m_phase == 0));
        check_eq("test_has_ended", 64'(test_has_ended), 64'(m_phase == 3));
        check_eq("overflow", 64'(overflow), 64'(m_overflow));
        check_eq("ovf_count", 64'(ovf_count), 64'(m_ovf));
        if (m_qw.size() > 0) begin
            check_eq("dct_buffer", 64'(dct_buffer), 64'(m_qw[0]));
            check_eq("dct_count", 64'(dct_count), 64'(m_qc[0]));
        end else if (m_after_rst) begin
            check_eq("dct_buffer_rst", 64'(dct_buffer), 64'(0));
            check_eq("dct_count_rst", 64'(dct_count), 64'(0));
        end
    endtask

    // One cycle per iteration: check, drive new inputs, advance the model.
    task automatic run_phase(input int n, input int p_valid, input int p_flush,
                             input int p_ready, input int p_end, input int p_rst);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_outputs();
            reset       = ($urandom_range(0, 99) < p_rst);
            slot_valid  = ($urandom_range(0, 99) < p_valid);
            slot_data   = SLOT_W'($urandom_range(0, 3));
            sync_flush  = ($urandom_range(0, 99) < p_flush);
            test_ending = ($urandom_range(0, 99) < p_end);
            out_ready   = ($urandom_range(0, 99) < p_ready);
            if (!reset && out_valid && out_ready) begin
                n_words++;
                $display("word %0d: dct_buffer=%08h dct_count=%0d", n_words, dct_buffer, dct_count);
            end
            model_step(reset, slot_valid, int'(slot_data), sync_flush, test_ending, out_ready);
        end
    endtask

    initial begin
        reset = 1'b1;
        slot_valid = 1'b0;
        slot_data = '0;
        sync_flush = 1'b0;
        test_ending = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // continuous slots, sink always ready: full words only
        run_phase(60, 100, 0, 100, 0, 0);
        // mixed density with partial flushes
        run_phase(300, 60, 10, 70, 0, 0);
        // sink stalled: FIFO fills and words are dropped
        run_phase(100, 100, 0, 0, 0, 0);
        run_phase(60, 100, 0, 100, 0, 0);
        // one word per cycle into a stalled sink: drive ovf_count to saturation
        run_phase(300, 100, 100, 0, 0, 0);
        // full FIFO with frequent push and pop in the same cycle
        run_phase(200, 70, 20, 50, 0, 0);
        // end of test: flush, drain, then inputs are ignored
        run_phase(2, 0, 0, 0, 0, 100);
        run_phase(40, 60, 5, 30, 0, 0);
        run_phase(1, 100, 0, 30, 100, 0);
        run_phase(60, 50, 20, 20, 0, 0);
        run_phase(100, 50, 20, 60, 0, 0);
        @(negedge clk);
        check_eq("ended_after_drain", 64'(test_has_ended), 64'(1));
        // reset while draining a loaded FIFO
        run_phase(2, 0, 0, 0, 0, 100);
        run_phase(80, 100, 0, 0, 0, 0);
        run_phase(1, 100, 0, 0, 100, 0);
        run_phase(5, 50, 0, 0, 0, 0);
        run_phase(1, 0, 0, 0, 0, 100);
        // random mix including occasional resets and end-of-test
        run_phase(400, 60, 10, 70, 2, 2);
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
